// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
package cpu_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam word_t FETCH_PC_INC   = 32'd4;
  localparam word_t FETCH_RESET_PC = 32'h0000_0000;

  function automatic word_t align_pc(input word_t pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - 32-bit address register with reset value and load enable
module pc_reg
  import cpu_pkg::*;
#(
  parameter word_t RESET_VAL = FETCH_RESET_PC
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  word_t d,
  output word_t q
);
  word_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) pc_d = d;
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_VAL;
    else        pc_q <= pc_d;
  end

  assign q = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, req/ack instruction-memory handshake and
// single-instruction presentation to the datapath with stall and redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = FETCH_RESET_PC,
  parameter word_t PC_INC   = FETCH_PC_INC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pcQ,
  output logic [31:0] pcD
);
  fetch_state_e state_q, state_d;
  logic  req_q, req_d, valid_q, valid_d;
  word_t instr_q, instr_d, pcq_q, pcq_d, pcd_q, pcd_d;
  word_t fetch_pc, target_pc, redir_tgt, fetch_nxt;
  logic  fetch_load, target_load;

  assign redir_tgt = align_pc(redirect_pc);

  pc_reg #(.RESET_VAL(RESET_PC)) u_fetch_pc (
    .clock(clock), .reset(reset), .load(fetch_load), .d(fetch_nxt), .q(fetch_pc)
  );

  pc_reg #(.RESET_VAL(RESET_PC)) u_target_pc (
    .clock(clock), .reset(reset), .load(target_load), .d(redir_tgt), .q(target_pc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pcq_d       = pcq_q;
    pcd_d       = pcd_q;
    fetch_load  = 1'b0;
    target_load = 1'b0;
    fetch_nxt   = redir_tgt;
    case (state_q)
      FETCH: begin
        req_d = 1'b1;
        if (redirect) begin
          // Only an unanswered outstanding request needs draining; otherwise retarget now.
          if (req_q && !imem_ack) begin
            state_d     = DISCARD;
            req_d       = 1'b0;
            target_load = 1'b1;
          end else begin
            fetch_load = 1'b1;
          end
        end else if (req_q && imem_ack) begin
          state_d = HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
          instr_d = imem_rdata;
          pcq_d   = fetch_pc;
          pcd_d   = fetch_pc + PC_INC;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_d    = FETCH;
          req_d      = 1'b1;
          valid_d    = 1'b0;
          fetch_load = 1'b1;
          if (!redirect) fetch_nxt = pcd_q;
        end
      end
      DISCARD: begin
        if (redirect) target_load = 1'b1;
        if (imem_ack) begin
          state_d    = FETCH;
          req_d      = 1'b1;
          fetch_load = 1'b1;
          fetch_nxt  = redirect ? redir_tgt : target_pc;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pcq_q   <= '0;
      pcd_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcq_q   <= pcq_d;
      pcd_q   <= pcd_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign pcQ         = pcq_q;
  assign pcD         = pcd_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle DataPath.
- Owns the fetch PC and runs a req/ack handshake to a variable-latency instruction memory.
- Presents one instruction at a time (instruction, pcQ, pcD) to the DataPath and honours downstream stall and branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset (bits [1:0] must be 0)
PC_INC, 4, byte increment between sequential instructions

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high
imem_req  output  1  request to instruction memory
imem_addr  output  32  word-aligned fetch address, valid while imem_req=1
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
stall  input  1  DataPath cannot consume presented instruction this cycle
redirect  input  1  branch/jump taken; discard current flow
redirect_pc  input  32  target address for redirect
instr_valid  output  1  instruction/pcQ/pcD are valid
instruction  output  32  fetched instruction word
pcQ  output  32  address of presented instruction
pcD  output  32  pcQ + PC_INC (sequential next PC)

Behaviour:
- Reset (sync, high), held any number of cycles:
  - state=FETCH, fetch_pc=RESET_PC, imem_req=0, instr_valid=0.
  - instruction=0, pcQ=0, pcD=0.
  - Memory shares reset, so no stale ack can follow reset.
- First cycle after reset low: imem_req=1, imem_addr=RESET_PC.
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - imem_req=1 and imem_addr=fetch_pc, both stable until ack.
  - On ack, next cycle: instruction=imem_rdata, pcQ=fetch_pc, pcD=fetch_pc+PC_INC, instr_valid=1, state=HOLD.
  - Minimum latency: ack in the req cycle gives instr_valid on the following cycle.
- HOLD:
  - imem_req=0; outputs held stable.
  - If !stall at the edge: instruction consumed; next cycle instr_valid=0, fetch_pc=pcD, state=FETCH.
  - If stall: all outputs unchanged.
  - Peak throughput is therefore one instruction per 2 cycles.
- DISCARD:
  - Entered when a request is outstanding but its data is no longer wanted.
  - imem_req=0 and instr_valid=0.
  - Wait for the stale ack; ignore its rdata; next cycle state=FETCH at target_pc.
- Redirect (priority over stall and ack), target = {redirect_pc[31:2],2'b00}:
  - HOLD: instruction dropped; next cycle instr_valid=0, fetch_pc=target, state=FETCH.
  - FETCH, no ack same cycle: target_pc=target, state=DISCARD.
  - FETCH, ack same cycle: rdata dropped, fetch_pc=target, state=FETCH with new address next cycle.
  - DISCARD: target_pc overwritten (last redirect wins). If ack arrives the same cycle, go to FETCH at the new target.
- Arithmetic: 32-bit unsigned; pc+PC_INC wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
- Unaligned redirect_pc is silently aligned, never flagged.
- instr_valid never asserts for a dropped or discarded word.

Decomposition:
- Shared package cpu_pkg:
  - typedef logic [31:0] word_t.
  - enum fetch_state_e {FETCH, HOLD, DISCARD}.
  - localparam PC_INC=4 and RESET_PC default.
- Sub-module pc_reg: 32-bit register with sync reset-to-parameter and load enable.
  - Used for fetch_pc and target_pc.
- FSM and output registers stay in fetch_unit.

Test Plan:
- Reset 3 cycles, mem ack latency 0, stall=0:
  - imem_addr sequence 0,4,8,C.
  - instr_valid every other cycle.
  - pcQ/pcD pairs (0,4),(4,8).
  - instruction matches preloaded words.
- Ack latency 3, stall high 4 cycles in HOLD:
  - imem_req high exactly 4 cycles per fetch.
  - instruction/pcQ frozen during stall.
  - next imem_addr = pcD only after stall drops.
- Redirect to 0x100 in HOLD with stall=1:
  - next cycle instr_valid=0.
  - imem_addr=0x100.
  - old word never re-presented.
- Redirect to 0x203 while request to 0x8 outstanding, ack 2 cycles later with 0xDEADBEEF:
  - DISCARD for 2 cycles.
  - 0xDEADBEEF never valid.
  - next fetch address 0x200.
- Redirect to 0x40 then 0x80 during DISCARD, plus redirect coincident with ack in FETCH:
  - fetch goes to 0x80.
  - coincident case drops rdata and refetches at target.
- Redirect to 0xFFFFFFFC then advance:
  - pcD=0x00000000.
  - next imem_addr=0x0.
- Reset asserted mid-FETCH and mid-HOLD:
  - next cycle all outputs 0.
  - imem_req low.
  - restart at RESET_PC.
